// File: rtl/sc_readout_sched.sv
// Output-side read scheduler: raster timing, replication phases and line-buffer read addresses.
// Every output is registered from the next counter state, so all of them line up with hcnt/vcnt.
// Optional frame lock reloads the raster on a misaligned input-frame trigger.
module sc_readout_sched #(
  parameter int H_TOTAL          = 1650,
  parameter int H_SYNCLEN        = 40,
  parameter int H_BACKPORCH      = 220,
  parameter int H_ACTIVE         = 1280,
  parameter int V_TOTAL          = 750,
  parameter int V_SYNCLEN        = 5,
  parameter int V_BACKPORCH      = 20,
  parameter int V_ACTIVE         = 720,
  parameter int SRC_H_ACTIVE     = 384,
  parameter int SRC_V_ACTIVE     = 224,
  parameter int H_MULT           = 3,
  parameter int V_MULT           = 3,
  parameter int NUM_LINE_BUFFERS = 40,
  parameter int LBUF_FIRST       = 1,
  parameter int V_LOCK_LINE      = 0,
  parameter int LOCK_FRAMES      = 2
) (
  input  logic        PCLK_in,
  input  logic        reset,
  input  logic        lock_en,
  input  logic        vsync_trig,
  output logic [10:0] hcnt_ext,
  output logic [10:0] vcnt_ext,
  output logic [8:0]  hcnt_ext_lbuf,
  output logic [5:0]  vcnt_ext_lbuf,
  output logic [2:0]  hctr_ext,
  output logic [2:0]  vctr_ext,
  output logic        HSYNC_ext,
  output logic        VSYNC_ext,
  output logic        DE_ext,
  output logic        mask_enable_ext,
  output logic        locked
);

  localparam int HDE0 = H_SYNCLEN + H_BACKPORCH;
  localparam int VDE0 = V_SYNCLEN + V_BACKPORCH;
  localparam int HW0  = HDE0 + (H_ACTIVE - SRC_H_ACTIVE * H_MULT) / 2;
  localparam int VW0  = VDE0 + (V_ACTIVE - SRC_V_ACTIVE * V_MULT) / 2;

  localparam logic [10:0] L_H_LAST = 11'(H_TOTAL - 1);
  localparam logic [10:0] L_V_LAST = 11'(V_TOTAL - 1);
  localparam logic [10:0] L_HS     = 11'(H_SYNCLEN);
  localparam logic [10:0] L_VS     = 11'(V_SYNCLEN);
  localparam logic [10:0] L_HDE0   = 11'(HDE0);
  localparam logic [10:0] L_HDE1   = 11'(HDE0 + H_ACTIVE);
  localparam logic [10:0] L_VDE0   = 11'(VDE0);
  localparam logic [10:0] L_VDE1   = 11'(VDE0 + V_ACTIVE);
  localparam logic [10:0] L_HW0    = 11'(HW0);
  localparam logic [10:0] L_HW1    = 11'(HW0 + SRC_H_ACTIVE * H_MULT);
  localparam logic [10:0] L_VW0    = 11'(VW0);
  localparam logic [10:0] L_VW1    = 11'(VW0 + SRC_V_ACTIVE * V_MULT);
  localparam logic [10:0] L_VLOCK  = 11'(V_LOCK_LINE);
  localparam logic [2:0]  L_HM_LAST = 3'(H_MULT - 1);
  localparam logic [2:0]  L_VM_LAST = 3'(V_MULT - 1);
  localparam logic [5:0]  L_LB_FIRST = 6'(LBUF_FIRST);
  localparam logic [5:0]  L_LB_LAST  = 6'(NUM_LINE_BUFFERS - 1);
  localparam int AW = $clog2(LOCK_FRAMES + 1);
  localparam int TW = $clog2(2 * V_TOTAL);
  localparam logic [AW-1:0] L_AC_LAST = AW'(LOCK_FRAMES - 1);
  localparam logic [TW-1:0] L_TO_LAST = TW'(2 * V_TOTAL - 1);

  typedef enum logic [1:0] {ST_FREE, ST_ACQUIRE, ST_LOCKED} state_t;

  state_t        r_state;
  logic [AW-1:0] r_acnt;
  logic [TW-1:0] r_tcnt;
  logic          r_locked;
  logic [10:0]   r_hcnt, r_vcnt;
  logic [8:0]    r_hlbuf;
  logic [5:0]    r_vlbuf;
  logic [2:0]    r_hctr, r_vctr;
  logic          r_hsync, r_vsync, r_de, r_mask;

  logic        w_h_wrap, w_aligned, w_reload, w_newline;
  logic        w_h_in_win, w_v_in_win, w_de_nxt;
  logic [10:0] w_h_nat, w_v_nat, w_h_nxt, w_v_nxt;
  logic [8:0]  w_hlbuf_nxt;
  logic [5:0]  w_vlbuf_nxt;
  logic [2:0]  w_hctr_nxt, w_vctr_nxt;

  // Natural counter advance, then override with the lock line on a misaligned trigger.
  always_comb begin
    w_h_wrap   = (r_hcnt == L_H_LAST);
    w_h_nat    = w_h_wrap ? 11'd0 : r_hcnt + 11'd1;
    w_v_nat    = r_vcnt;
    if (w_h_wrap) w_v_nat = (r_vcnt == L_V_LAST) ? 11'd0 : r_vcnt + 11'd1;
    w_aligned  = (w_h_nat == 11'd0) && (w_v_nat == L_VLOCK);
    w_reload   = vsync_trig && lock_en && (r_state != ST_FREE) && !w_aligned;
    w_h_nxt    = w_reload ? 11'd0 : w_h_nat;
    w_v_nxt    = w_reload ? L_VLOCK : w_v_nat;
    w_newline  = (w_h_nxt == 11'd0);
    w_h_in_win = (w_h_nxt >= L_HW0) && (w_h_nxt < L_HW1);
    w_v_in_win = (w_v_nxt >= L_VW0) && (w_v_nxt < L_VW1);
    w_de_nxt   = (w_h_nxt >= L_HDE0) && (w_h_nxt < L_HDE1) &&
                 (w_v_nxt >= L_VDE0) && (w_v_nxt < L_VDE1);
  end

  // Horizontal replication phase and source column; restart at the window's left edge.
  always_comb begin
    w_hctr_nxt  = 3'd0;
    w_hlbuf_nxt = 9'd0;
    if (w_h_in_win && (w_h_nxt != L_HW0)) begin
      if (r_hctr == L_HM_LAST) begin
        w_hlbuf_nxt = r_hlbuf + 9'd1;
      end else begin
        w_hctr_nxt  = r_hctr + 3'd1;
        w_hlbuf_nxt = r_hlbuf;
      end
    end
  end

  // Vertical phase and buffer index change only at the start of a line.
  // The lock line is expected to sit outside the vertical window, so a reload never lands mid-picture.
  always_comb begin
    w_vctr_nxt  = r_vctr;
    w_vlbuf_nxt = r_vlbuf;
    if (w_newline) begin
      if (!w_v_in_win) begin
        w_vctr_nxt  = 3'd0;
        w_vlbuf_nxt = 6'd0;
      end else if (w_v_nxt == L_VW0) begin
        w_vctr_nxt  = 3'd0;
        w_vlbuf_nxt = L_LB_FIRST;
      end else if (r_vctr == L_VM_LAST) begin
        w_vctr_nxt  = 3'd0;
        w_vlbuf_nxt = (r_vlbuf == L_LB_LAST) ? 6'd0 : r_vlbuf + 6'd1;
      end else begin
        w_vctr_nxt  = r_vctr + 3'd1;
      end
    end
  end

  // Register counters and every derived output from the same next-state values.
  always_ff @(posedge PCLK_in or posedge reset) begin
    if (reset) begin
      r_hcnt  <= 11'd0;
      r_vcnt  <= 11'd0;
      r_hctr  <= 3'd0;
      r_vctr  <= 3'd0;
      r_hlbuf <= 9'd0;
      r_vlbuf <= 6'd0;
      r_hsync <= 1'b1;
      r_vsync <= 1'b1;
      r_de    <= 1'b0;
      r_mask  <= 1'b0;
    end else begin
      r_hcnt  <= w_h_nxt;
      r_vcnt  <= w_v_nxt;
      r_hctr  <= w_hctr_nxt;
      r_vctr  <= w_vctr_nxt;
      r_hlbuf <= w_hlbuf_nxt;
      r_vlbuf <= w_vlbuf_nxt;
      r_hsync <= !(w_h_nxt < L_HS);
      r_vsync <= !(w_v_nxt < L_VS);
      r_de    <= w_de_nxt;
      r_mask  <= w_de_nxt && !(w_h_in_win && w_v_in_win);
    end
  end

  // Lock FSM: count aligned triggers, drop lock on a misaligned trigger or a missing-trigger timeout.
  always_ff @(posedge PCLK_in or posedge reset) begin
    if (reset) begin
      r_state  <= ST_FREE;
      r_acnt   <= '0;
      r_tcnt   <= '0;
      r_locked <= 1'b0;
    end else if (!lock_en) begin
      r_state  <= ST_FREE;
      r_acnt   <= '0;
      r_tcnt   <= '0;
      r_locked <= 1'b0;
    end else begin
      case (r_state)
        ST_FREE: begin
          r_state <= ST_ACQUIRE;
          r_acnt  <= '0;
          r_tcnt  <= '0;
        end
        ST_ACQUIRE: begin
          if (vsync_trig) begin
            r_tcnt <= '0;
            if (!w_aligned) begin
              r_acnt <= '0;
            end else if (r_acnt == L_AC_LAST) begin
              r_acnt   <= '0;
              r_state  <= ST_LOCKED;
              r_locked <= 1'b1;
            end else begin
              r_acnt <= r_acnt + 1'b1;
            end
          end else if (w_h_wrap) begin
            if (r_tcnt == L_TO_LAST) begin
              r_tcnt <= '0;
              r_acnt <= '0;
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
        end
        ST_LOCKED: begin
          if (vsync_trig) begin
            r_tcnt <= '0;
            if (!w_aligned) begin
              r_state  <= ST_ACQUIRE;
              r_locked <= 1'b0;
              r_acnt   <= '0;
            end
          end else if (w_h_wrap) begin
            if (r_tcnt == L_TO_LAST) begin
              r_tcnt   <= '0;
              r_acnt   <= '0;
              r_state  <= ST_ACQUIRE;
              r_locked <= 1'b0;
            end else begin
              r_tcnt <= r_tcnt + 1'b1;
            end
          end
        end
        default: begin
          r_state  <= ST_FREE;
          r_locked <= 1'b0;
        end
      endcase
    end
  end

  assign hcnt_ext        = r_hcnt;
  assign vcnt_ext        = r_vcnt;
  assign hcnt_ext_lbuf   = r_hlbuf;
  assign vcnt_ext_lbuf   = r_vlbuf;
  assign hctr_ext        = r_hctr;
  assign vctr_ext        = r_vctr;
  assign HSYNC_ext       = r_hsync;
  assign VSYNC_ext       = r_vsync;
  assign DE_ext          = r_de;
  assign mask_enable_ext = r_mask;
  assign locked          = r_locked;

endmodule

// File: tb/tb_sc_readout_sched.sv
// Directed bench for sc_readout_sched using a reduced raster (40 x 30, 1200 cycles per frame).
// Derived geometry: DE h 10..33, v 5..24; window h 13..30 (x3), v 7..21 (x3); 4 line buffers.
// Outputs sampled on the falling clock edge; vsync_trig driven on the falling edge.
module tb_sc_readout_sched;

  logic        PCLK_in = 1'b0;
  logic        reset;
  logic        lock_en;
  logic        vsync_trig;
  logic [10:0] hcnt_ext, vcnt_ext;
  logic [8:0]  hcnt_ext_lbuf;
  logic [5:0]  vcnt_ext_lbuf;
  logic [2:0]  hctr_ext, vctr_ext;
  logic        HSYNC_ext, VSYNC_ext, DE_ext, mask_enable_ext, locked;

  int checks = 0;
  int errors = 0;

  always #5 PCLK_in = ~PCLK_in;

  sc_readout_sched #(
    .H_TOTAL(40), .H_SYNCLEN(4), .H_BACKPORCH(6), .H_ACTIVE(24),
    .V_TOTAL(30), .V_SYNCLEN(2), .V_BACKPORCH(3), .V_ACTIVE(20),
    .SRC_H_ACTIVE(6), .SRC_V_ACTIVE(5), .H_MULT(3), .V_MULT(3),
    .NUM_LINE_BUFFERS(4), .LBUF_FIRST(1), .V_LOCK_LINE(0), .LOCK_FRAMES(2)
  ) dut (
    .PCLK_in(PCLK_in), .reset(reset), .lock_en(lock_en), .vsync_trig(vsync_trig),
    .hcnt_ext(hcnt_ext), .vcnt_ext(vcnt_ext), .hcnt_ext_lbuf(hcnt_ext_lbuf),
    .vcnt_ext_lbuf(vcnt_ext_lbuf), .hctr_ext(hctr_ext), .vctr_ext(vctr_ext),
    .HSYNC_ext(HSYNC_ext), .VSYNC_ext(VSYNC_ext), .DE_ext(DE_ext),
    .mask_enable_ext(mask_enable_ext), .locked(locked)
  );

  // Advance at least one cycle, then until the raster shows (h, v); bounded.
  task automatic goto(input int h, input int v);
    int  n = 0;
    bit  found = 1'b0;
    while (!found && n < 3000) begin
      @(negedge PCLK_in);
      n++;
      if (int'(hcnt_ext) == h && int'(vcnt_ext) == v) found = 1'b1;
    end
    if (!found) begin
      checks++; errors++;
      $display("FAIL goto(%0d,%0d): not reached in 3000 cycles, now at (%0d,%0d)", h, v, hcnt_ext, vcnt_ext);
    end
  endtask

  // One-cycle trigger sampled at the next rising edge; returns on the following falling edge.
  task automatic pulse_trig();
    vsync_trig = 1'b1;
    @(negedge PCLK_in);
    vsync_trig = 1'b0;
  endtask

  task automatic test_reset();
    checks++;
    if ({hcnt_ext, vcnt_ext, hcnt_ext_lbuf, vcnt_ext_lbuf, hctr_ext, vctr_ext,
         HSYNC_ext, VSYNC_ext, DE_ext, mask_enable_ext, locked} !== {49'd0, 1'b1, 1'b1, 3'b000}) begin
      errors++;
      $display("FAIL reset_values: h=%0d v=%0d hl=%0d vl=%0d hc=%0d vc=%0d hs=%b vs=%b de=%b m=%b lk=%b",
               hcnt_ext, vcnt_ext, hcnt_ext_lbuf, vcnt_ext_lbuf, hctr_ext, vctr_ext,
               HSYNC_ext, VSYNC_ext, DE_ext, mask_enable_ext, locked);
    end
    @(negedge PCLK_in);
    reset = 1'b0;
    @(negedge PCLK_in);
    checks++;
    if (hcnt_ext !== 11'd1 || vcnt_ext !== 11'd0 || HSYNC_ext !== 1'b0) begin
      errors++;
      $display("FAIL first_cycle: got (%0d,%0d) hs=%b, want (1,0) hs=0", hcnt_ext, vcnt_ext, HSYNC_ext);
    end
  endtask

  task automatic test_sync_de();
    // {h, v, hsync, vsync, de}
    int tbl [10][5] = '{
      '{3, 0, 0, 0, 0}, '{4, 0, 1, 0, 0}, '{39, 1, 1, 0, 0}, '{0, 2, 0, 1, 0},
      '{10, 4, 1, 1, 0}, '{9, 5, 1, 1, 0}, '{10, 5, 1, 1, 1}, '{33, 24, 1, 1, 1},
      '{34, 24, 1, 1, 0}, '{10, 25, 1, 1, 0}};
    for (int i = 0; i < 10; i++) begin
      goto(tbl[i][0], tbl[i][1]);
      checks++;
      if (int'(HSYNC_ext) !== tbl[i][2] || int'(VSYNC_ext) !== tbl[i][3] || int'(DE_ext) !== tbl[i][4]) begin
        errors++;
        $display("FAIL sync_de@(%0d,%0d): hs/vs/de got %b%b%b want %0d%0d%0d", tbl[i][0], tbl[i][1],
                 HSYNC_ext, VSYNC_ext, DE_ext, tbl[i][2], tbl[i][3], tbl[i][4]);
      end
    end
  endtask

  task automatic test_window();
    // {h, v, mask, hctr, hlbuf}
    int tbl [9][5] = '{
      '{9, 7, 0, 0, 0}, '{10, 7, 1, 0, 0}, '{12, 7, 1, 0, 0}, '{13, 7, 0, 0, 0},
      '{15, 7, 0, 2, 0}, '{16, 7, 0, 0, 1}, '{30, 7, 0, 2, 5}, '{31, 7, 1, 0, 0},
      '{34, 7, 0, 0, 0}};
    for (int i = 0; i < 9; i++) begin
      goto(tbl[i][0], tbl[i][1]);
      checks++;
      if (int'(mask_enable_ext) !== tbl[i][2] || int'(hctr_ext) !== tbl[i][3] ||
          int'(hcnt_ext_lbuf) !== tbl[i][4]) begin
        errors++;
        $display("FAIL window@(%0d,%0d): mask/hctr/hlbuf got %0d/%0d/%0d want %0d/%0d/%0d",
                 tbl[i][0], tbl[i][1], mask_enable_ext, hctr_ext, hcnt_ext_lbuf, tbl[i][2], tbl[i][3], tbl[i][4]);
      end
    end
  endtask

  task automatic test_vertical();
    // {h, v, vctr, vlbuf, mask}
    int tbl [12][5] = '{
      '{20, 6, 0, 0, 1}, '{0, 7, 0, 1, 0}, '{20, 7, 0, 1, 0}, '{20, 8, 1, 1, 0},
      '{20, 9, 2, 1, 0}, '{20, 10, 0, 2, 0}, '{20, 13, 0, 3, 0}, '{20, 15, 2, 3, 0},
      '{20, 16, 0, 0, 0}, '{20, 19, 0, 1, 0}, '{20, 21, 2, 1, 0}, '{20, 22, 0, 0, 1}};
    for (int i = 0; i < 12; i++) begin
      goto(tbl[i][0], tbl[i][1]);
      checks++;
      if (int'(vctr_ext) !== tbl[i][2] || int'(vcnt_ext_lbuf) !== tbl[i][3] ||
          int'(mask_enable_ext) !== tbl[i][4]) begin
        errors++;
        $display("FAIL vertical@(%0d,%0d): vctr/vlbuf/mask got %0d/%0d/%0d want %0d/%0d/%0d",
                 tbl[i][0], tbl[i][1], vctr_ext, vcnt_ext_lbuf, mask_enable_ext, tbl[i][2], tbl[i][3], tbl[i][4]);
      end
    end
  endtask

  task automatic test_frame_counts();
    int n_de = 0, n_hs = 0, n_vs = 0, n_mask = 0;
    goto(0, 0);
    for (int i = 0; i < 1200; i++) begin
      n_de   += int'(DE_ext);
      n_hs   += int'(!HSYNC_ext);
      n_vs   += int'(!VSYNC_ext);
      n_mask += int'(mask_enable_ext);
      @(negedge PCLK_in);
    end
    checks++;
    if (n_de !== 480 || n_hs !== 120 || n_vs !== 80 || n_mask !== 210) begin
      errors++;
      $display("FAIL frame_counts: de/hs/vs/mask got %0d/%0d/%0d/%0d want 480/120/80/210", n_de, n_hs, n_vs, n_mask);
    end
    checks++;
    if (hcnt_ext !== 11'd0 || vcnt_ext !== 11'd0) begin
      errors++;
      $display("FAIL frame_wrap: got (%0d,%0d) want (0,0)", hcnt_ext, vcnt_ext);
    end
  endtask

  task automatic test_lock_acquire();
    lock_en = 1'b1;
    goto(20, 10);
    pulse_trig();
    checks++;
    if (hcnt_ext !== 11'd0 || vcnt_ext !== 11'd0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL acquire_reload: got (%0d,%0d) locked=%b want (0,0) locked=0", hcnt_ext, vcnt_ext, locked);
    end
    goto(39, 29);
    pulse_trig();
    checks++;
    if (locked !== 1'b0 || hcnt_ext !== 11'd0 || vcnt_ext !== 11'd0) begin
      errors++;
      $display("FAIL acquire_first_aligned: got (%0d,%0d) locked=%b want (0,0) locked=0", hcnt_ext, vcnt_ext, locked);
    end
    goto(39, 29);
    pulse_trig();
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL acquire_locked: locked=%b want 1", locked);
    end
    @(negedge PCLK_in);
    checks++;
    if (hcnt_ext !== 11'd1 || vcnt_ext !== 11'd0) begin
      errors++;
      $display("FAIL aligned_no_double_step: got (%0d,%0d) want (1,0)", hcnt_ext, vcnt_ext);
    end
  endtask

  task automatic test_lock_loss();
    goto(29, 29);
    pulse_trig();
    checks++;
    if (hcnt_ext !== 11'd0 || vcnt_ext !== 11'd0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL loss_early_trig: got (%0d,%0d) locked=%b want (0,0) locked=0", hcnt_ext, vcnt_ext, locked);
    end
    repeat (70 * 40) @(negedge PCLK_in);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL loss_no_trig: locked=%b want 0", locked);
    end
    // Still acquiring after the timeout: a misaligned trigger must reload.
    goto(20, 10);
    pulse_trig();
    checks++;
    if (hcnt_ext !== 11'd0 || vcnt_ext !== 11'd0) begin
      errors++;
      $display("FAIL loss_still_acquire: got (%0d,%0d) want (0,0)", hcnt_ext, vcnt_ext);
    end
  endtask

  task automatic test_timeout();
    goto(39, 29);
    pulse_trig();
    goto(39, 29);
    pulse_trig();
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL timeout_relock: locked=%b want 1", locked);
    end
    goto(39, 29);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL timeout_early: locked=%b want 1 after 30 lines", locked);
    end
    goto(39, 29);
    checks++;
    if (locked !== 1'b1) begin
      errors++;
      $display("FAIL timeout_edge: locked=%b want 1 before 60th wrap", locked);
    end
    @(negedge PCLK_in);
    checks++;
    if (locked !== 1'b0) begin
      errors++;
      $display("FAIL timeout_drop: locked=%b want 0 after 60 wraps", locked);
    end
  endtask

  task automatic test_lock_disable();
    goto(5, 3);
    lock_en = 1'b0;
    pulse_trig();
    checks++;
    if (hcnt_ext !== 11'd6 || vcnt_ext !== 11'd3 || locked !== 1'b0) begin
      errors++;
      $display("FAIL disable_no_reload: got (%0d,%0d) locked=%b want (6,3) locked=0", hcnt_ext, vcnt_ext, locked);
    end
    goto(20, 10);
    pulse_trig();
    checks++;
    if (hcnt_ext !== 11'd21 || vcnt_ext !== 11'd10) begin
      errors++;
      $display("FAIL free_ignores_trig: got (%0d,%0d) want (21,10)", hcnt_ext, vcnt_ext);
    end
  endtask

  task automatic test_reset_midop();
    lock_en = 1'b1;
    goto(39, 29);
    pulse_trig();
    goto(39, 29);
    pulse_trig();
    goto(17, 12);
    checks++;
    if (locked !== 1'b1 || hctr_ext !== 3'd1 || hcnt_ext_lbuf !== 9'd1 || vctr_ext !== 3'd2 || vcnt_ext_lbuf !== 6'd2) begin
      errors++;
      $display("FAIL pre_reset_state: lk=%b hc=%0d hl=%0d vc=%0d vl=%0d want 1/1/1/2/2",
               locked, hctr_ext, hcnt_ext_lbuf, vctr_ext, vcnt_ext_lbuf);
    end
    #2 reset = 1'b1;
    #1;
    checks++;
    if ({hcnt_ext, vcnt_ext, hcnt_ext_lbuf, vcnt_ext_lbuf, hctr_ext, vctr_ext,
         HSYNC_ext, VSYNC_ext, DE_ext, mask_enable_ext, locked} !== {49'd0, 1'b1, 1'b1, 3'b000}) begin
      errors++;
      $display("FAIL async_reset: h=%0d v=%0d hl=%0d vl=%0d hc=%0d vc=%0d hs=%b vs=%b de=%b m=%b lk=%b",
               hcnt_ext, vcnt_ext, hcnt_ext_lbuf, vcnt_ext_lbuf, hctr_ext, vctr_ext,
               HSYNC_ext, VSYNC_ext, DE_ext, mask_enable_ext, locked);
    end
    lock_en = 1'b0;
    @(negedge PCLK_in);
    reset = 1'b0;
    @(negedge PCLK_in);
    checks++;
    if (hcnt_ext !== 11'd1 || vcnt_ext !== 11'd0 || locked !== 1'b0) begin
      errors++;
      $display("FAIL post_reset_run: got (%0d,%0d) locked=%b want (1,0) locked=0", hcnt_ext, vcnt_ext, locked);
    end
  endtask

  initial begin
    reset      = 1'b1;
    lock_en    = 1'b0;
    vsync_trig = 1'b0;
    #12;
    test_reset();
    test_sync_de();
    test_window();
    test_vertical();
    test_frame_counts();
    test_lock_acquire();
    test_lock_loss();
    test_timeout();
    test_lock_disable();
    test_reset_midop();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
